// File: rtl/pc_sequencer.sv
// Fetch-side program counter with sequential/branch/jump next-PC selection
// and an exception redirect that inserts one squash bubble.
//
// state | meaning
// BOOT  | first cycle out of reset, fetch bubble, PC held at RESET_VECTOR
// RUN   | normal fetch, instruction may commit, PC advances every edge
// TRAP  | squash bubble after an exception redirect, PC held at EXC_VECTOR
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [1:0]       Jump,
  input  logic             Branch,
  input  logic             BranchNot,
  input  logic             Zero,
  input  logic             Exception,
  input  logic [15:0]      Imm16,
  input  logic [25:0]      Target26,
  input  logic [31:0]      RegA,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             InstrValid,
  output logic [31:0]      EPC,
  output logic             ExcTaken,
  output logic [CNT_W-1:0] ExcCount
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc_q, pc_nxt;
  logic [31:0]      epc_q, epc_nxt;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_nxt;
  logic             exc_taken_q, exc_taken_nxt;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_offset;
  logic             br_taken;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{Imm16[15]}}, Imm16, 2'b00};
  assign br_taken  = (Jump == 2'b01) && Branch && (Zero ^ BranchNot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc_q        <= RESET_VECTOR;
      epc_q       <= 32'h0000_0000;
      exc_cnt_q   <= '0;
      exc_taken_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      epc_q       <= epc_nxt;
      exc_cnt_q   <= exc_cnt_nxt;
      exc_taken_q <= exc_taken_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    epc_nxt       = epc_q;
    exc_cnt_nxt   = exc_cnt_q;
    exc_taken_nxt = 1'b0;
    if (!Stall) begin
      case (state)
        BOOT: state_nxt = RUN;
        TRAP: state_nxt = RUN;
        RUN: begin
          if (Exception) begin
            pc_nxt        = EXC_VECTOR;
            epc_nxt       = pc_q;
            exc_taken_nxt = 1'b1;
            state_nxt     = TRAP;
            if (exc_cnt_q != {CNT_W{1'b1}})
              exc_cnt_nxt = exc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (Jump == 2'b11) begin
            pc_nxt = RegA;
          end else if (Jump == 2'b10) begin
            pc_nxt = {pc_plus4[31:28], Target26, 2'b00};
          end else if (br_taken) begin
            pc_nxt = pc_plus4 + br_offset;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign InstrValid = (state == RUN);
  assign EPC        = epc_q;
  assign ExcTaken   = exc_taken_q;
  assign ExcCount   = exc_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, branches, jumps, exceptions,
// stall, counter saturation and asynchronous reset.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [1:0]  Jump;
  logic        Branch;
  logic        BranchNot;
  logic        Zero;
  logic        Exception;
  logic [15:0] Imm16;
  logic [25:0] Target26;
  logic [31:0] RegA;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic [31:0] EPC;
  logic        ExcTaken;
  logic [7:0]  ExcCount;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .Jump       (Jump),
    .Branch     (Branch),
    .BranchNot  (BranchNot),
    .Zero       (Zero),
    .Exception  (Exception),
    .Imm16      (Imm16),
    .Target26   (Target26),
    .RegA       (RegA),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .InstrValid (InstrValid),
    .EPC        (EPC),
    .ExcTaken   (ExcTaken),
    .ExcCount   (ExcCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    Jump      = 2'b00;
    Branch    = 1'b0;
    BranchNot = 1'b0;
    Zero      = 1'b0;
    Exception = 1'b0;
  endtask

  task automatic jr_to(input logic [31:0] addr);
    clear_ctl();
    Jump = 2'b11;
    RegA = addr;
    step();
    clear_ctl();
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Imm16 = 16'h0; Target26 = 26'h0; RegA = 32'h0;
    clear_ctl();
    #3;
    check("rst_pc", PC, 32'h0);
    check("rst_iv", 32'(InstrValid), 32'd0);
    check("rst_epc", EPC, 32'h0);
    check("rst_cnt", 32'(ExcCount), 32'd0);
    check("rst_taken", 32'(ExcTaken), 32'd0);
    check("rst_pcp4", PCPlus4, 32'h4);
    step();
    reset = 1'b0;

    step();
    check("boot_pc", PC, 32'h0);
    check("boot_iv", 32'(InstrValid), 32'd1);
    step();
    check("seq_pc4", PC, 32'h4);
    step();
    check("seq_pc8", PC, 32'h8);
    check("seq_iv", 32'(InstrValid), 32'd1);

    jr_to(32'h40);
    check("jr_40", PC, 32'h40);
    Jump = 2'b01; Branch = 1'b1; BranchNot = 1'b0; Zero = 1'b1; Imm16 = 16'hFFFE;
    step();
    check("beq_taken_back", PC, 32'h3C);

    jr_to(32'h40);
    Jump = 2'b01; Branch = 1'b1; BranchNot = 1'b1; Zero = 1'b1; Imm16 = 16'hFFFE;
    step();
    check("bne_not_taken", PC, 32'h44);
    Jump = 2'b01; Branch = 1'b1; BranchNot = 1'b1; Zero = 1'b0; Imm16 = 16'h0010;
    step();
    check("bne_taken_fwd", PC, 32'h88);
    Jump = 2'b01; Branch = 1'b0; BranchNot = 1'b0; Zero = 1'b1; Imm16 = 16'h0010;
    step();
    check("j01_nobranch_seq", PC, 32'h8C);
    Jump = 2'b01; Branch = 1'b1; BranchNot = 1'b0; Zero = 1'b0;
    step();
    check("beq_not_taken", PC, 32'h90);
    clear_ctl();

    jr_to(32'h1000_0010);
    Jump = 2'b10; Target26 = 26'h0000100;
    step();
    check("j_target", PC, 32'h1000_0400);
    Jump = 2'b11; RegA = 32'h0000_2000;
    step();
    check("jr_2000", PC, 32'h2000);

    jr_to(32'h24);
    Exception = 1'b1; Jump = 2'b11; RegA = 32'h0000_0999;
    step();
    check("exc_pc", PC, 32'h180);
    check("exc_epc", EPC, 32'h24);
    check("exc_taken", 32'(ExcTaken), 32'd1);
    check("exc_iv", 32'(InstrValid), 32'd0);
    check("exc_cnt", 32'(ExcCount), 32'd1);
    step();
    check("trap_hold_pc", PC, 32'h180);
    check("trap_no_nest_cnt", 32'(ExcCount), 32'd1);
    check("trap_taken_drop", 32'(ExcTaken), 32'd0);
    check("trap_iv_back", 32'(InstrValid), 32'd1);
    clear_ctl();
    step();
    check("after_trap_seq", PC, 32'h184);

    Stall = 1'b1; Exception = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", PC, 32'h184);
      check("stall_epc", EPC, 32'h24);
      check("stall_taken", 32'(ExcTaken), 32'd0);
    end
    Stall = 1'b0;
    step();
    check("unstall_exc_pc", PC, 32'h180);
    check("unstall_exc_epc", EPC, 32'h184);
    check("unstall_exc_cnt", 32'(ExcCount), 32'd2);
    clear_ctl();
    step();

    jr_to(32'hFFFF_FFFC);
    check("wrap_pcp4", PCPlus4, 32'h0);
    step();
    check("wrap_pc", PC, 32'h0);

    for (int i = 0; i < 252; i++) begin
      Exception = 1'b1; step();
      Exception = 1'b0; step();
    end
    check("cnt_254", 32'(ExcCount), 32'd254);
    for (int i = 0; i < 6; i++) begin
      Exception = 1'b1; step();
      Exception = 1'b0; step();
    end
    check("cnt_sat", 32'(ExcCount), 32'd255);

    jr_to(32'h50);
    Exception = 1'b1;
    step();
    check("pre_rst_taken", 32'(ExcTaken), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midtrap_rst_pc", PC, 32'h0);
    check("midtrap_rst_epc", EPC, 32'h0);
    check("midtrap_rst_cnt", 32'(ExcCount), 32'd0);
    check("midtrap_rst_taken", 32'(ExcTaken), 32'd0);
    check("midtrap_rst_iv", 32'(InstrValid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side program-counter stage that sits directly upstream of the instruction decoder/control unit.
- Holds the PC, drives the instruction-memory address, and computes the next PC from the decoder's Jump/Branch/Exception outputs, the ALU zero flag and the instruction fields.
- Captures the faulting PC on an illegal instruction and redirects to the exception vector with a one-cycle squash bubble.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on an exception redirect.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- Stall  input  1  holds PC and all state for the cycle.
- Jump  input  2  00 seq, 01 branch, 10 j/jal, 11 jr (from control).
- Branch  input  1  conditional-branch instruction (from control).
- BranchNot  input  1  opCode[0]; 1 = bne, 0 = beq.
- Zero  input  1  ALU zero flag for the current instruction.
- Exception  input  1  illegal-instruction flag (from control).
- Imm16  input  16  instruction [15:0].
- Target26  input  26  instruction [25:0].
- RegA  input  32  rs read data, used by jr.
- PC  output  32  current fetch address.
- PCPlus4  output  32  PC+4, the jal link value.
- InstrValid  output  1  current instruction may commit; 0 = bubble.
- EPC  output  32  PC of the last excepting instruction.
- ExcTaken  output  1  one-cycle pulse when a redirect is taken.
- ExcCount  output  CNT_W  saturating count of exceptions taken.

Behaviour:
- Reset values (immediate on reset assertion): PC=RESET_VECTOR, EPC=0, ExcCount=0, ExcTaken=0, state=BOOT, InstrValid=0.
- Reset mid-operation aborts any redirect, with no partial EPC update.
- States:
  - BOOT: InstrValid=0. Goes to RUN on the next non-stalled edge; PC stays at RESET_VECTOR.
  - RUN: InstrValid=1. PC updates every non-stalled edge per the selection rules below.
  - TRAP: InstrValid=0 (squash bubble). Goes to RUN on the next non-stalled edge; PC is held at EXC_VECTOR.
- Next-PC selection in RUN, priority highest first:
  - Exception=1 -> PC<=EXC_VECTOR, EPC<=PC, ExcTaken<=1 (one-cycle pulse), ExcCount+=1 saturating at all-ones, state<=TRAP.
  - Jump=11 -> PC<=RegA (no alignment check).
  - Jump=10 -> PC<={PCPlus4[31:28], Target26, 2'b00}.
  - Jump=01 and Branch=1 and (Zero XOR BranchNot)=1 -> PC<=PCPlus4 + (sign-extended Imm16 << 2), mod 2^32.
  - Otherwise -> PC<=PCPlus4.
- Jump=01 with Branch=0 is treated as sequential.
- PCPlus4 = PC+4 combinationally; it wraps 32'hFFFF_FFFC -> 0.
- Stall=1 overrides everything:
  - PC, EPC, ExcCount and state hold.
  - ExcTaken=0.
  - A pending Exception is taken on the first non-stalled edge if it is still asserted.
- Exception, Jump and Branch are ignored while InstrValid=0 (BOOT/TRAP), so there is no nested trap on a bubble.
- ExcTaken is registered and high for exactly the cycle after the redirect edge, i.e. the TRAP cycle.
- Latency: a redirect takes effect one edge after decode (PC register), plus one bubble cycle for exceptions only.

Test Plan:
- Reset release, Stall=0, Jump=00 -> PC=0 with InstrValid=0 for 1 cycle, then PC=0, 4, 8 with InstrValid=1.
- Branch taken, backward: PC=0x40, Jump=01, Branch=1, BranchNot=0, Zero=1, Imm16=16'hFFFE -> next PC=0x3C.
- Branch not taken: same, but BranchNot=1 (bne) -> next PC=0x44.
- Jumps:
  - PC=0x1000_0010, Jump=10, Target26=26'h0000100 -> PC=0x1000_0400.
  - Jump=11, RegA=0x0000_2000 -> PC=0x2000.
- Exception and squash: PC=0x24, Exception=1 -> next PC=0x180, EPC=0x24, ExcTaken=1 for one cycle, InstrValid=0 for one cycle, ExcCount=1. Exception held high during the TRAP cycle -> no second trap.
- Stall and saturation:
  - Stall=1 with Exception=1 for 3 cycles -> PC/EPC unchanged; the trap is taken on the first cycle after Stall drops.
  - 260 exceptions with CNT_W=8 -> ExcCount saturates at 255.
  - Reset asserted mid-TRAP -> all outputs return to reset values immediately.
